fetch_unit: RTL

- Instruction-fetch stage: owns the program counter, issues single-outstanding requests to instruction memory, and holds the fetched instruction in the IF slot (`if_pc`/`if_instr`/`if_valid`), which the branch predictor observes.
- On consumption the slot advances into the IF/ID pipeline register, and the PC loads the predictor's `next_predicted_pc`.
- On `branch_prediction_failed` it flushes IF and ID and discards any in-flight stale response.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction-fetch stage. Owns the program counter, issues one outstanding
// request at a time to instruction memory, holds the returned word in the IF
// slot (observed by the branch predictor), and advances it into the IF/ID
// register when the slot is consumed. A mispredict (branch_prediction_failed
// while not stalled) flushes IF and ID, redirects the PC, and discards any
// response still in flight for the abandoned address.
//
// Ports:
//   clk                      system clock, rising edge
//   rst                      synchronous, active-high reset
//   stall                    hazard hold: freezes IF slot, ID register and PC
//   next_predicted_pc        next PC from the branch predictor
//   branch_prediction_failed mispredict: flush and redirect
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            fetch address (current PC)
//   imem_resp_valid/data     fetch response
//   if_pc/if_instr/if_valid  IF slot contents (NOP when empty)
//   id_pc/id_instr/id_valid  IF/ID pipeline register

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [63:0] next_predicted_pc,
    input  logic        branch_prediction_failed,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request presented, waiting for acceptance
        S_WAIT  = 2'd1,  // request accepted, waiting for response
        S_HOLD  = 2'd2,  // IF slot full, waiting to be consumed
        S_DRAIN = 2'd3   // discarding a stale in-flight response
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic        req_valid_q;
    logic        redirect;

    // A stalled mispredict waits: the predictor keeps the flag asserted.
    assign redirect = branch_prediction_failed & ~stall;

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ: begin
                // Accepted together with a redirect: that response is stale.
                if (imem_req_ready)
                    state_nxt = redirect ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect)
                    state_nxt = imem_resp_valid ? S_REQ : S_DRAIN;
                else if (imem_resp_valid)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // Either a consume or a redirect empties the slot.
                if (~stall)
                    state_nxt = S_REQ;
            end
            S_DRAIN: begin
                if (imem_resp_valid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            req_valid_q <= 1'b1;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP;
            if_pc       <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc       <= '0;
        end else begin
            state       <= state_nxt;
            req_valid_q <= (state_nxt == S_REQ);

            if (redirect) begin
                pc       <= next_predicted_pc;
                if_valid <= 1'b0;
                if_instr <= NOP;
                id_valid <= 1'b0;
                id_instr <= NOP;
            end else if (state == S_HOLD) begin
                if (~stall) begin
                    id_pc    <= if_pc;
                    id_instr <= if_instr;
                    id_valid <= 1'b1;
                    pc       <= next_predicted_pc;
                    if_valid <= 1'b0;
                    if_instr <= NOP;
                end
            end else begin
                // IF has nothing to hand over: bubble into ID unless held.
                if (~stall) begin
                    id_valid <= 1'b0;
                    id_instr <= NOP;
                end
                // The slot is empty here, so a response is captured even
                // under stall.
                if (state == S_WAIT && imem_resp_valid) begin
                    if_valid <= 1'b1;
                    if_pc    <= pc;
                    if_instr <= imem_resp_data;
                end
            end
        end
    end

endmodule
